// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - serial bit-pattern detector with fill tracking and saturating match counter
module seq_pattern_detector #(
    parameter int             LEN     = 6,
    parameter logic [LEN-1:0] PAT_A   = 6'b011101,
    parameter logic [LEN-1:0] PAT_B   = 6'b011001,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             X,
    input  logic             MODE,
    input  logic             CLR,
    output logic             Z,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic             ARMED
);

    localparam int               FW        = $clog2(LEN + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(LEN);
    localparam logic [FW-1:0]    FILL_LAST = FW'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Only the newest LEN-1 bits are kept: the oldest bit of the window is
    // shifted out on the same edge it would be compared, so it never needs storage.
    logic [LEN-2:0]   hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             z_q, z_d;

    logic [LEN-1:0]   window;
    logic [LEN-1:0]   pattern;
    logic             match;

    // Candidate window and match decision for the current sampling edge
    always_comb begin
        window  = {hist_q, X};
        pattern = MODE ? PAT_A : PAT_B;
        match   = EN && !CLR && (fill_q >= FILL_LAST) && (window == pattern);
    end

    // Next-state: clear wins over enable; a disabled edge holds everything but drops Z
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        z_d    = 1'b0;
        if (CLR) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (EN) begin
            hist_d = window[LEN-2:0];
            z_d    = match;
            if (match && !OVERLAP) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
            if (match && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous reset that discards any partial window
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            z_q    <= z_d;
        end
    end

    assign Z         = z_q;
    assign MATCH_CNT = cnt_q;
    assign ARMED     = (fill_q == FILL_FULL);

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - directed self-checking bench for seq_pattern_detector
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       mode = 1'b1;
    logic       clr = 1'b0;

    logic       z0, arm0;
    logic [7:0] cnt0;
    logic       z1, arm1;
    logic [7:0] cnt1;
    logic       z2, arm2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_pattern_detector u_ovl (
        .CLK(clk), .RST(rst), .EN(en), .X(x), .MODE(mode), .CLR(clr),
        .Z(z0), .MATCH_CNT(cnt0), .ARMED(arm0)
    );

    seq_pattern_detector #(.OVERLAP(1'b0)) u_novl (
        .CLK(clk), .RST(rst), .EN(en), .X(x), .MODE(mode), .CLR(clr),
        .Z(z1), .MATCH_CNT(cnt1), .ARMED(arm1)
    );

    seq_pattern_detector #(.OVERLAP(1'b0), .CNT_W(2)) u_sat (
        .CLK(clk), .RST(rst), .EN(en), .X(x), .MODE(mode), .CLR(clr),
        .Z(z2), .MATCH_CNT(cnt2), .ARMED(arm2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one edge's inputs away from the edge, then sample just after it
    task automatic step(input logic e, input logic b, input logic c);
        @(negedge clk);
        en  = e;
        x   = b;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [5:0]  pat_a = 6'b011101;
    logic [9:0]  s31   = 10'b0110011001;
    logic [4:0]  s32   = 5'b11101;

    initial begin
        // reset state
        #2;
        check("rst_z", {31'd0, z0}, 32'd0);
        check("rst_cnt", {24'd0, cnt0}, 32'd0);
        check("rst_armed", {31'd0, arm0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // single PAT_A match, one-cycle pulse
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, pat_a[5-i], 1'b0);
            check($sformatf("r30_z%0d", i), {31'd0, z0}, (i == 5) ? 32'd1 : 32'd0);
        end
        check("r30_cnt", {24'd0, cnt0}, 32'd1);
        check("r30_armed", {31'd0, arm0}, 32'd1);
        step(1'b0, 1'b1, 1'b0);
        check("r30_z_drop", {31'd0, z0}, 32'd0);
        check("r30_hold_cnt", {24'd0, cnt0}, 32'd1);
        check("r30_hold_armed", {31'd0, arm0}, 32'd1);

        // synchronous clear, with EN high to show clear wins
        step(1'b1, 1'b1, 1'b1);
        check("clr_cnt", {24'd0, cnt0}, 32'd0);
        check("clr_armed", {31'd0, arm0}, 32'd0);
        check("clr_z", {31'd0, z0}, 32'd0);

        // PAT_B stream, overlapping versus restarting
        mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, s31[9-i], 1'b0);
            check($sformatf("r31_ovl_z%0d", i), {31'd0, z0}, (i == 5 || i == 9) ? 32'd1 : 32'd0);
            check($sformatf("r31_novl_z%0d", i), {31'd0, z1}, (i == 5) ? 32'd1 : 32'd0);
        end
        check("r31_ovl_cnt", {24'd0, cnt0}, 32'd2);
        check("r31_novl_cnt", {24'd0, cnt1}, 32'd1);

        // five bits after reset never match even though the window looks right
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, s32[4-i], 1'b0);
            check($sformatf("r32_z%0d", i), {31'd0, z0}, 32'd0);
        end
        check("r32_armed", {31'd0, arm0}, 32'd0);

        // PAT_A with disabled edges interleaved, X toggling while disabled
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, pat_a[5-i], 1'b0);
            check($sformatf("r33_z%0d", i), {31'd0, z0}, (i == 5) ? 32'd1 : 32'd0);
            step(1'b0, ~pat_a[5-i], 1'b0);
            check($sformatf("r33_zoff%0d", i), {31'd0, z0}, 32'd0);
        end
        check("r33_cnt", {24'd0, cnt0}, 32'd1);

        // asynchronous reset mid-sequence
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pat_a[5-i], 1'b0);
            check($sformatf("r34_pre_z%0d", i), {31'd0, z0}, 32'd0);
        end
        rst = 1'b1;
        #2;
        check("r34_async_z", {31'd0, z0}, 32'd0);
        check("r34_async_cnt", {24'd0, cnt0}, 32'd0);
        check("r34_async_armed", {31'd0, arm0}, 32'd0);
        rst = 1'b0;
        for (int i = 4; i < 6; i++) begin
            step(1'b1, pat_a[5-i], 1'b0);
            check($sformatf("r34_post_z%0d", i), {31'd0, z0}, 32'd0);
        end
        check("r34_armed", {31'd0, arm0}, 32'd0);

        // 2-bit counter saturates across back-to-back restarting matches
        do_reset();
        for (int m = 0; m < 5; m++) begin
            for (int i = 0; i < 6; i++) begin
                step(1'b1, pat_a[5-i], 1'b0);
            end
            check($sformatf("r35_z%0d", m), {31'd0, z2}, 32'd1);
            check($sformatf("r35_cnt%0d", m), {30'd0, cnt2}, (m < 3) ? m + 1 : 32'd3);
        end
        step(1'b0, 1'b0, 1'b1);
        check("r35_clr_cnt", {30'd0, cnt2}, 32'd0);
        check("r35_clr_z", {31'd0, z2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
